// File: rtl/lc3_pkg.sv
// Shared LC-3 sequencer definitions: opcodes, ALU op encodings, FSM states
// and the sign-extension / condition-code helpers.
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [1:0] ALUK_ADD   = 2'b00;
   localparam logic [1:0] ALUK_AND   = 2'b01;
   localparam logic [1:0] ALUK_NOT   = 2'b10;
   localparam logic [1:0] ALUK_PASSA = 2'b11;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   function automatic logic [15:0] sext5(input logic [4:0] v);
      return {{11{v[4]}}, v};
   endfunction

   function automatic logic [15:0] sext9(input logic [8:0] v);
      return {{7{v[8]}}, v};
   endfunction

   // Exactly one of {N,Z,P} is set for any value.
   function automatic logic [2:0] nzp_of(input logic [15:0] v);
      if (v[15])
         return 3'b100;
      else if (v == 16'h0000)
         return 3'b010;
      else
         return 3'b001;
   endfunction

endpackage

// File: rtl/lc3_op_sequencer_if.sv
// Instruction-fetch port and ALU port of the LC-3 sequencer; the sequencer
// is the master of both.
interface lc3_op_sequencer_if;

   // Fetch handshake: a beat transfers on a rising edge where mem_req && mem_rdy.
   // mem_addr is held stable while mem_req is high; mem_rdata is only looked
   // at on the transferring edge.
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_rdy;
   logic [15:0] mem_rdata;

   logic [1:0]  alu_aluk;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_out;

   modport master (
      output mem_req, mem_addr, alu_aluk, alu_a, alu_b,
      input  mem_rdy, mem_rdata, alu_out
   );

   modport slave (
      input  mem_req, mem_addr, alu_aluk, alu_a, alu_b,
      output mem_rdy, mem_rdata, alu_out
   );

endinterface

// File: rtl/lc3_regfile.sv
// 8x16 LC-3 register file: two combinational read ports, one synchronous
// write port, asynchronous active-low clear.
module lc3_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [2:0]  waddr,
   input  logic [15:0] wdata,
   input  logic [2:0]  raddr_a,
   output logic [15:0] rdata_a,
   input  logic [2:0]  raddr_b,
   output logic [15:0] rdata_b
);

   logic [15:0] regs [8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/lc3_op_sequencer.sv
// Multi-cycle LC-3 sequencer (FETCH/DECODE/EXECUTE/HALT) running ADD, AND, NOT, BR.
// Optional retired-instruction counter enabled by LC3_RETIRE_CNT_EN.
module lc3_op_sequencer
   import lc3_pkg::*;
#(
   parameter int          WIDTH    = 16,
   parameter logic [15:0] PC_RESET = 16'h3000
) (
   input  logic               clk,
   input  logic               rst_n,
   lc3_op_sequencer_if.master bus,
   output logic [WIDTH-1:0]   pc,
   output logic [2:0]         nzp,
   output logic               halted,
   output logic               illegal,
   output state_t             state
`ifdef LC3_RETIRE_CNT_EN
   ,
   output logic [WIDTH-1:0]   retired
`endif
);

   logic [WIDTH-1:0] ir;
   logic             mem_req;
   logic [1:0]       aluk;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;

   logic [3:0]       opcode;
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;
   logic [WIDTH-1:0] operand_b;
   logic             is_alu_op;
   logic             br_taken;
   logic             rf_we;

   assign opcode    = ir[15:12];
   assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
   assign operand_b = ir[5] ? sext5(ir[4:0]) : rdata_b;
   assign br_taken  = (ir[11:9] & nzp) != 3'b000;
   assign rf_we     = (state == S_EXECUTE) && is_alu_op;

   lc3_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (ir[11:9]),
      .wdata   (bus.alu_out),
      .raddr_a (ir[8:6]),
      .rdata_a (rdata_a),
      .raddr_b (ir[2:0]),
      .rdata_b (rdata_b)
   );

   // Operands are latched at the end of DECODE so the ALU sees registered
   // inputs throughout EXECUTE; outside EXECUTE the ALU is parked on PASSA of 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         pc      <= PC_RESET;
         ir      <= '0;
         nzp     <= 3'b010;
         halted  <= 1'b0;
         illegal <= 1'b0;
         mem_req <= 1'b0;
         aluk    <= ALUK_PASSA;
         alu_a   <= '0;
         alu_b   <= '0;
`ifdef LC3_RETIRE_CNT_EN
         retired <= '0;
`endif
      end else begin
         case (state)
            S_FETCH: begin
               if (!mem_req) begin
                  mem_req <= 1'b1;
               end else if (bus.mem_rdy) begin
                  ir      <= bus.mem_rdata;
                  pc      <= pc + 16'd1;
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_ADD, OP_AND: begin
                     aluk  <= (opcode == OP_ADD) ? ALUK_ADD : ALUK_AND;
                     alu_a <= rdata_a;
                     alu_b <= operand_b;
                     state <= S_EXECUTE;
                  end
                  OP_NOT: begin
                     aluk  <= ALUK_NOT;
                     alu_a <= rdata_a;
                     alu_b <= '0;
                     state <= S_EXECUTE;
                  end
                  OP_BR: begin
                     state <= S_EXECUTE;
                  end
                  OP_TRAP: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: begin
                     halted  <= 1'b1;
                     illegal <= 1'b1;
                     state   <= S_HALT;
                  end
               endcase
            end
            S_EXECUTE: begin
               if (is_alu_op)
                  nzp <= nzp_of(bus.alu_out);
               else if (br_taken)
                  pc <= pc + sext9(ir[8:0]);
               aluk    <= ALUK_PASSA;
               alu_a   <= '0;
               alu_b   <= '0;
               mem_req <= 1'b1;
               state   <= S_FETCH;
`ifdef LC3_RETIRE_CNT_EN
               retired <= retired + 16'd1;
`endif
            end
            default: begin
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req  = mem_req;
   assign bus.mem_addr = pc;
   assign bus.alu_aluk = aluk;
   assign bus.alu_a    = alu_a;
   assign bus.alu_b    = alu_b;

endmodule

// File: tb/tb_lc3_op_sequencer.sv
// Directed bench for lc3_op_sequencer: memory responder, ALU model and an
// expected fetch-address queue; hand-computed results for each instruction.
module tb_lc3_op_sequencer;
  import lc3_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [2:0]  nzp;
  logic        halted;
  logic        illegal;
  state_t      state;
`ifdef LC3_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  int checks;
  int failures;
  logic [15:0] exp_q[$];

  lc3_op_sequencer_if bus ();

  lc3_op_sequencer #(.WIDTH(16), .PC_RESET(16'h3000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .pc      (pc),
    .nzp     (nzp),
    .halted  (halted),
    .illegal (illegal),
    .state   (state)
`ifdef LC3_RETIRE_CNT_EN
    ,
    .retired (retired)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model
  always_comb begin
    bus.alu_out = 16'h0000;
    case (bus.alu_aluk)
      2'b00:   bus.alu_out = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_out = bus.alu_a & bus.alu_b;
      2'b10:   bus.alu_out = ~bus.alu_a;
      default: bus.alu_out = bus.alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc, 16'h3000);
    check("rst_nzp", 16'(nzp), 16'h0002);
    check("rst_halted", 16'(halted), 16'h0000);
    check("rst_illegal", 16'(illegal), 16'h0000);
    check("rst_mem_req", 16'(bus.mem_req), 16'h0000);
    check("rst_state", 16'(state), 16'(S_FETCH));
    check("rst_aluk", 16'(bus.alu_aluk), 16'h0003);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.mem_rdy = 1'b0;
    bus.mem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
  endtask

  // driver: serve one fetch, optionally stalling; returns at the negedge in DECODE
  task automatic fetch(input logic [15:0] instr, input int stall);
    logic [15:0] exp_addr;
    int n;
    exp_addr = exp_q.pop_front();
    n = 0;
    while (!bus.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_req) begin
      check("fetch_timeout", 16'(bus.mem_req), 16'h0001);
      return;
    end
    check("fetch_addr", bus.mem_addr, exp_addr);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_req", 16'(bus.mem_req), 16'h0001);
      check("stall_addr", bus.mem_addr, exp_addr);
      check("stall_state", 16'(state), 16'(S_FETCH));
    end
    bus.mem_rdy = 1'b1;
    bus.mem_rdata = instr;
    @(negedge clk);
    bus.mem_rdy = 1'b0;
    bus.mem_rdata = 16'hDEAD;
  endtask

  task automatic exec_op(input logic [15:0] instr, input logic [15:0] addr, input int stall,
                         input logic [1:0] exp_aluk, input logic [15:0] exp_a,
                         input logic [15:0] exp_b, input logic [2:0] exp_nzp,
                         input logic [15:0] exp_pc);
    exp_q.push_back(addr);
    fetch(instr, stall);
    @(negedge clk);
    check("ex_aluk", 16'(bus.alu_aluk), 16'(exp_aluk));
    check("ex_a", bus.alu_a, exp_a);
    check("ex_b", bus.alu_b, exp_b);
    @(negedge clk);
    check("wb_nzp", 16'(nzp), 16'(exp_nzp));
    check("wb_pc", pc, exp_pc);
    check("wb_aluk", 16'(bus.alu_aluk), 16'h0003);
  endtask

  task automatic exec_br(input logic [15:0] instr, input logic [15:0] addr,
                         input logic [15:0] exp_pc);
    exp_q.push_back(addr);
    fetch(instr, 0);
    @(negedge clk);
    check("br_aluk", 16'(bus.alu_aluk), 16'h0003);
    @(negedge clk);
    check("br_pc", pc, exp_pc);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    apply_reset();

    exec_op(16'h1262, 16'h3000, 0, 2'b00, 16'h0000, 16'h0002, 3'b001, 16'h3001); // ADD R1,R1,#2
    exec_op(16'h5660, 16'h3001, 0, 2'b01, 16'h0002, 16'h0000, 3'b010, 16'h3002); // AND R3,R1,#0
    exec_op(16'h987F, 16'h3002, 0, 2'b10, 16'h0002, 16'h0000, 3'b100, 16'h3003); // NOT R4,R1
    exec_br(16'h09FE, 16'h3003, 16'h3002);                                        // BRn taken
    exec_op(16'h1262, 16'h3002, 0, 2'b00, 16'h0002, 16'h0002, 3'b001, 16'h3003); // R1=4
    exec_br(16'h09FE, 16'h3003, 16'h3004);                                        // BRn not taken
    exec_op(16'h1B03, 16'h3004, 0, 2'b00, 16'hFFFD, 16'h0000, 3'b100, 16'h3005); // ADD R5,R4,R3
    exec_op(16'h147C, 16'h3005, 0, 2'b00, 16'h0004, 16'hFFFC, 3'b010, 16'h3006); // ADD R2,R1,#-4
    exec_br(16'h0403, 16'h3006, 16'h300A);                                        // BRz +3 taken
    exec_br(16'h0005, 16'h300A, 16'h300B);                                        // BR none: never
    exec_op(16'h1D42, 16'h300B, 5, 2'b00, 16'hFFFD, 16'h0000, 3'b100, 16'h300C); // stalled fetch
`ifdef LC3_RETIRE_CNT_EN
    check("retired", retired, 16'd11);
`endif

    // TRAP halts without flagging illegal
    exp_q.push_back(16'h300C);
    fetch(16'hF025, 0);
    @(negedge clk);
    check("trap_halted", 16'(halted), 16'h0001);
    check("trap_illegal", 16'(illegal), 16'h0000);
    check("trap_state", 16'(state), 16'(S_HALT));
    repeat (4) @(negedge clk);
    check("trap_req", 16'(bus.mem_req), 16'h0000);
    check("trap_pc", pc, 16'h300D);

    // unsupported opcode
    apply_reset();
    exp_q.push_back(16'h3000);
    fetch(16'h2000, 0);
    @(negedge clk);
    check("ill_halted", 16'(halted), 16'h0001);
    check("ill_illegal", 16'(illegal), 16'h0001);
    repeat (3) @(negedge clk);
    check("ill_req", 16'(bus.mem_req), 16'h0000);

    // reset pulsed mid-fetch while a data beat is on the bus
    apply_reset();
    begin
      int n;
      n = 0;
      while (!bus.mem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("midrst_req_seen", 16'(bus.mem_req), 16'h0001);
      bus.mem_rdy = 1'b1;
      bus.mem_rdata = 16'h1262;
      #2 rst_n = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      bus.mem_rdy = 1'b0;
      check("midrst_pc_held", pc, 16'h3000);
      rst_n = 1'b1;
    end
    exec_op(16'h1262, 16'h3000, 0, 2'b00, 16'h0000, 16'h0002, 3'b001, 16'h3001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
